// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and constants for the SRAM controller
package sram_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, FINISH} state_t;

  typedef enum logic {REQ_A, REQ_B} req_id_t;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/sram_rr_arb.sv
// rtl/sram_rr_arb.sv - two-way round-robin arbiter; grants only while enabled
module sram_rr_arb
  import sram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt,
  output req_id_t    winner
);

  req_id_t last_served;

  // req[0] is port A, req[1] is port B; on a tie the port not served last wins
  always_comb begin
    gnt    = 2'b00;
    winner = REQ_A;
    if (enable) begin
      if (req[0] && (!req[1] || last_served == REQ_B)) begin
        gnt    = 2'b01;
        winner = REQ_A;
      end else if (req[1]) begin
        gnt    = 2'b10;
        winner = REQ_B;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_served <= REQ_B;
    end else if (|gnt) begin
      last_served <= winner;
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - two-port asynchronous SRAM sequencer with wait states
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_adr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_done,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_adr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_done,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [ADDR_WIDTH-1:0] sram_adr,
  output logic [DATA_WIDTH-1:0] sram_dq_out,
  output logic                  sram_dq_oe,
  input  logic [DATA_WIDTH-1:0] sram_dq_in
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("sram_ctrl: WAIT_CYCLES must be within 1..15");
  end

  state_t                  state, next_state;
  logic [WAIT_W-1:0]       cnt;
  logic                    we_q;
  req_id_t                 owner_q;
  logic [1:0]              arb_gnt;
  req_id_t                 arb_winner;
  logic                    arb_en;
  logic                    take;
  logic                    win_we;
  logic [ADDR_WIDTH-1:0]   win_adr;
  logic [DATA_WIDTH-1:0]   win_wdata;
  logic                    cur_we;
  logic                    last_access;
  logic                    ce_n_d, oe_n_d, we_n_d, dq_oe_d;

  assign arb_en = (state == IDLE);

  sram_rr_arb u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({b_req, a_req}),
    .enable  (arb_en),
    .gnt     (arb_gnt),
    .winner  (arb_winner)
  );

  assign a_gnt       = arb_gnt[0];
  assign b_gnt       = arb_gnt[1];
  assign take        = |arb_gnt;
  assign win_we      = (arb_winner == REQ_A) ? a_we    : b_we;
  assign win_adr     = (arb_winner == REQ_A) ? a_adr   : b_adr;
  assign win_wdata   = (arb_winner == REQ_A) ? a_wdata : b_wdata;
  assign cur_we      = take ? win_we : we_q;
  assign last_access = (state == ACCESS) && (cnt == '0);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (take) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (cnt == '0) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes are registered, so they are decoded from the state being entered
  always_comb begin
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    case (next_state)
      SETUP: begin
        ce_n_d  = 1'b0;
        oe_n_d  = cur_we;
        dq_oe_d = cur_we;
      end
      ACCESS: begin
        ce_n_d  = 1'b0;
        oe_n_d  = cur_we;
        we_n_d  = !cur_we;
        dq_oe_d = cur_we;
      end
      FINISH:  dq_oe_d = cur_we;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      owner_q    <= REQ_A;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
    end else begin
      state      <= next_state;
      sram_ce_n  <= ce_n_d;
      sram_oe_n  <= oe_n_d;
      sram_we_n  <= we_n_d;
      sram_dq_oe <= dq_oe_d;
      if (take) begin
        we_q    <= win_we;
        owner_q <= arb_winner;
      end
      if (state == SETUP) begin
        cnt <= WAIT_W'(WAIT_CYCLES - 1);
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Address and write data only move on a grant, long after we_n has risen
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_adr    <= '0;
      sram_dq_out <= '0;
    end else if (take) begin
      sram_adr <= win_adr;
      if (win_we) sram_dq_out <= win_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_done  <= 1'b0;
      b_done  <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_done <= last_access && (owner_q == REQ_A);
      b_done <= last_access && (owner_q == REQ_B);
      if (last_access && !we_q) begin
        if (owner_q == REQ_A) a_rdata <= sram_dq_in;
        else                  b_rdata <= sram_dq_in;
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - directed self-checking bench for sram_ctrl
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_req, a_we, a_gnt, a_done;
  logic [15:0] a_adr, a_wdata, a_rdata;
  logic        b_req, b_we, b_gnt, b_done;
  logic [15:0] b_adr, b_wdata, b_rdata;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe;
  logic [15:0] sram_adr, sram_dq_out, sram_dq_in;
  logic [15:0] mem [0:65535];

  logic        w1_req, w1_gnt, w1_done, w1_bgnt, w1_bdone;
  logic [15:0] w1_ardata, w1_brdata, w1_adr, w1_dq;
  logic        w1_ce, w1_oe, w1_we, w1_dqoe;
  logic        w15_req, w15_gnt, w15_done, w15_bgnt, w15_bdone;
  logic [15:0] w15_ardata, w15_brdata, w15_adr, w15_dq;
  logic        w15_ce, w15_oe, w15_we, w15_dqoe;

  int tests = 0;
  int fails = 0;
  int inv_err = 0;

  logic [3:0]  v_ce, v_oe, v_we, v_dqoe, v_adone, v_bdone;
  logic [15:0] v_adr;

  always #5 clk = ~clk;

  sram_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_adr(sram_adr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in)
  );

  sram_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .reset_n(reset_n),
    .a_req(w1_req), .a_we(1'b0), .a_adr(16'h0000), .a_wdata(16'h0000),
    .a_gnt(w1_gnt), .a_done(w1_done), .a_rdata(w1_ardata),
    .b_req(1'b0), .b_we(1'b0), .b_adr(16'h0000), .b_wdata(16'h0000),
    .b_gnt(w1_bgnt), .b_done(w1_bdone), .b_rdata(w1_brdata),
    .sram_ce_n(w1_ce), .sram_oe_n(w1_oe), .sram_we_n(w1_we),
    .sram_adr(w1_adr), .sram_dq_out(w1_dq), .sram_dq_oe(w1_dqoe),
    .sram_dq_in(16'h5a5a)
  );

  sram_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WAIT_CYCLES(15)) dut_w15 (
    .clk(clk), .reset_n(reset_n),
    .a_req(w15_req), .a_we(1'b0), .a_adr(16'h0000), .a_wdata(16'h0000),
    .a_gnt(w15_gnt), .a_done(w15_done), .a_rdata(w15_ardata),
    .b_req(1'b0), .b_we(1'b0), .b_adr(16'h0000), .b_wdata(16'h0000),
    .b_gnt(w15_bgnt), .b_done(w15_bdone), .b_rdata(w15_brdata),
    .sram_ce_n(w15_ce), .sram_oe_n(w15_oe), .sram_we_n(w15_we),
    .sram_adr(w15_adr), .sram_dq_out(w15_dq), .sram_dq_oe(w15_dqoe),
    .sram_dq_in(16'h5a5a)
  );

  // Behavioural SRAM: drives data while selected and read-enabled
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_adr] : 16'h0000;

  always @(posedge clk) begin
    if (!sram_we_n && !sram_ce_n) mem[sram_adr] <= sram_dq_out;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      inv_err <= inv_err + int'(!sram_oe_n && sram_dq_oe)
                         + int'(!sram_we_n && (sram_ce_n || !sram_dq_oe));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One access on the chosen port; records strobes for the 4 cycles after gnt
  task automatic access(input bit port, input bit we, input logic [15:0] adr, input logic [15:0] wd);
    logic g;
    int   n;
    @(negedge clk);
    if (!port) begin a_req = 1'b1; a_we = we; a_adr = adr; a_wdata = wd; end
    else       begin b_req = 1'b1; b_we = we; b_adr = adr; b_wdata = wd; end
    #1;
    g = port ? b_gnt : a_gnt;
    n = 0;
    while (!g && n < 20) begin
      @(negedge clk); #1;
      g = port ? b_gnt : a_gnt;
      n++;
    end
    check("gnt_seen", g, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin a_req = 1'b0; b_req = 1'b0; end
      #1;
      v_ce[k] = sram_ce_n;  v_oe[k] = sram_oe_n;  v_we[k] = sram_we_n;
      v_dqoe[k] = sram_dq_oe; v_adone[k] = a_done; v_bdone[k] = b_done;
      if (k == 0) v_adr = sram_adr;
    end
  endtask

  task automatic measure(input int sel, input int exp_lat, input string tag);
    logic g, d;
    int   lat;
    @(negedge clk);
    if (sel == 1) w1_req = 1'b1; else w15_req = 1'b1;
    #1;
    g = (sel == 1) ? w1_gnt : w15_gnt;
    check({tag, "_gnt"}, g, 1);
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      w1_req = 1'b0; w15_req = 1'b0;
      #1;
      d = (sel == 1) ? w1_done : w15_done;
      if (d) lat = n;
    end
    check(tag, lat, exp_lat);
  endtask

  int g_cyc [8];
  int g_id  [8];
  int ng, wrong, last_own, bdone_cnt;

  initial begin
    reset_n = 1'b0;
    a_req = 0; a_we = 0; a_adr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_adr = 0; b_wdata = 0;
    w1_req = 0; w15_req = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
    check("rst_adr", sram_adr, 16'h0000);
    check("rst_dq_out", sram_dq_out, 16'h0000);
    check("rst_rdata", {a_rdata, b_rdata}, 32'h0);
    check("rst_done", {a_done, b_done}, 2'b00);
    check("rst_gnt", {a_gnt, b_gnt}, 2'b00);
    reset_n = 1'b1;

    access(0, 1'b1, 16'h0010, 16'h1234);
    check("wa_ce", v_ce, 4'b1000);
    check("wa_oe", v_oe, 4'b1111);
    check("wa_we", v_we, 4'b1001);
    check("wa_dqoe", v_dqoe, 4'b1111);
    check("wa_adone", v_adone, 4'b1000);
    check("wa_adr", v_adr, 16'h0010);

    access(0, 1'b0, 16'h0010, 16'h0000);
    check("ra_ce", v_ce, 4'b1000);
    check("ra_oe", v_oe, 4'b1000);
    check("ra_we", v_we, 4'b1111);
    check("ra_dqoe", v_dqoe, 4'b0000);
    check("ra_adone", v_adone, 4'b1000);
    check("ra_bdone", v_bdone, 4'b0000);
    check("ra_rdata", a_rdata, 16'h1234);

    access(1, 1'b1, 16'h0020, 16'hBEEF);
    check("wb_we", v_we, 4'b1001);
    check("wb_dqoe", v_dqoe, 4'b1111);
    check("wb_bdone", v_bdone, 4'b1000);
    check("wb_adone", v_adone, 4'b0000);
    check("wb_brdata_kept", b_rdata, 16'h0000);
    check("wb_ardata_kept", a_rdata, 16'h1234);

    access(0, 1'b0, 16'h0020, 16'h0000);
    check("ra20_rdata", a_rdata, 16'hBEEF);
    access(1, 1'b0, 16'h0010, 16'h0000);
    check("rb10_rdata", b_rdata, 16'h1234);
    check("rb10_ardata_kept", a_rdata, 16'hBEEF);
    access(0, 1'b1, 16'h0030, 16'h5555);
    access(1, 1'b0, 16'h0030, 16'h0000);
    check("rb30_rdata", b_rdata, 16'h5555);

    // Both ports requesting continuously out of reset
    @(negedge clk);
    reset_n = 1'b0;
    a_req = 1; a_we = 0; a_adr = 16'h0010;
    b_req = 1; b_we = 0; b_adr = 16'h0020;
    @(negedge clk);
    reset_n = 1'b1;
    ng = 0; wrong = 0; last_own = -1;
    for (int c = 0; c < 22; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (a_gnt && b_gnt) wrong++;
      if (a_gnt) begin last_own = 0; if (ng < 8) begin g_cyc[ng] = c; g_id[ng] = 0; ng++; end end
      if (b_gnt) begin last_own = 1; if (ng < 8) begin g_cyc[ng] = c; g_id[ng] = 1; ng++; end end
      if (a_done && last_own != 0) wrong++;
      if (b_done && last_own != 1) wrong++;
    end
    a_req = 0; b_req = 0;
    check("arb_count", ng >= 4, 1);
    for (int i = 0; i < 4 && i < ng; i++) begin
      check($sformatf("arb_order%0d", i), g_id[i], i % 2);
      if (i > 0) check($sformatf("arb_space%0d", i), g_cyc[i] - g_cyc[i-1], 5);
    end
    check("arb_wrong_port", wrong, 0);
    check("arb_a_rdata", a_rdata, 16'h1234);
    check("arb_b_rdata", b_rdata, 16'hBEEF);
    repeat (6) @(negedge clk);

    // Reset while B is in the ACCESS state of a write
    @(negedge clk);
    b_req = 1; b_we = 1; b_adr = 16'h0040; b_wdata = 16'hCAFE;
    #1;
    check("mid_gnt", b_gnt, 1);
    @(negedge clk); b_req = 0;
    @(negedge clk); #1;
    check("mid_we_low", sram_we_n, 0);
    reset_n = 1'b0;
    #1;
    check("mid_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
    @(negedge clk);
    reset_n = 1'b1;
    bdone_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (b_done) bdone_cnt++;
    end
    check("mid_no_bdone", bdone_cnt, 0);
    @(negedge clk);
    a_req = 1; a_we = 0; a_adr = 16'h0010;
    b_req = 1; b_we = 0; b_adr = 16'h0020;
    #1;
    check("post_rst_a_first", {a_gnt, b_gnt}, 2'b10);
    @(negedge clk);
    a_req = 0; b_req = 0;
    repeat (6) @(negedge clk);

    measure(1, 3, "lat_w1");
    measure(15, 17, "lat_w15");

    check("bus_invariants", inv_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Sequences the team's asynchronous SRAM (active-low ce/oe/we, shared bidirectional data bus) from a single synchronous clock domain. Two requesters share it: port A (core) and port B (peripheral/DMA). Ports are arbitrated round-robin, and each accepted request becomes one timed read or write cycle with programmable wait states. Sits between the requesters and the top-level SRAM pads. The pad tristate lives at top level: data = sram_dq_oe ? sram_dq_out : 'z.

Parameters:
ADDR_WIDTH, 16, SRAM address width
DATA_WIDTH, 16, SRAM data width
WAIT_CYCLES, 2, ACCESS-state length in clocks; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
a_req  in  1  port A request; held with a_we/a_adr/a_wdata stable until a_gnt
a_we  in  1  1=write, 0=read
a_adr  in  ADDR_WIDTH  port A address
a_wdata  in  DATA_WIDTH  port A write data
a_gnt  out  1  port A request accepted (1-cycle pulse)
a_done  out  1  port A access complete (1-cycle pulse)
a_rdata  out  DATA_WIDTH  port A read data; valid while a_done=1 after a read
b_req, b_we, b_adr, b_wdata, b_gnt, b_done, b_rdata  same as port A, for port B
sram_ce_n  out  1  SRAM chip enable, active low
sram_oe_n  out  1  SRAM output enable, active low
sram_we_n  out  1  SRAM write enable, active low
sram_adr  out  ADDR_WIDTH  SRAM address
sram_dq_out  out  DATA_WIDTH  write data to pad
sram_dq_oe  out  1  pad drive enable
sram_dq_in  in  DATA_WIDTH  data from pad

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - all *_n strobes = 1; sram_dq_oe = 0; sram_adr, sram_dq_out, a_rdata, b_rdata = 0
  - gnt/done = 0; state = IDLE; last_served = B, so A wins the first tie
- All sram_* outputs and done/rdata are registered; gnt is combinational.
- FSM states: IDLE -> SETUP -> ACCESS -> FINISH -> IDLE.
- IDLE:
  - gnt is asserted to the arbiter winner only in IDLE.
  - On the gnt edge, latch we/adr/wdata and the owner id, then go to SETUP.
  - With no request, remain in IDLE.
- SETUP (1 cycle):
  - ce_n=0 and adr driven.
  - Read: oe_n=0.
  - Write: dq_oe=1 and dq_out=wdata; we_n stays 1.
- ACCESS (WAIT_CYCLES cycles, down-counter):
  - ce_n=0.
  - Read: oe_n=0; on the final ACCESS edge, capture sram_dq_in into the owner's rdata.
  - Write: we_n=0 and dq_oe=1.
- FINISH (1 cycle):
  - ce_n, oe_n, we_n all 1; dq_oe stays 1 for writes (data hold) and 0 for reads.
  - Owner's done=1. Next state is IDLE.
- Latency: gnt at cycle T gives done at T+2+WAIT_CYCLES. The earliest next gnt is at T+3+WAIT_CYCLES; per-access occupancy is WAIT_CYCLES+3.
- Bus safety invariants, never violated:
  - oe_n=0 and dq_oe=1 are never both true in the same cycle.
  - we_n=0 implies ce_n=0 and dq_oe=1.
  - we_n rises at least 1 cycle before adr or dq_out change.
- Arbitration:
  - Only one requester asserting: it wins.
  - Both asserting in IDLE: the port not equal to last_served wins.
  - last_served updates on every gnt.
- Requests and done:
  - A requester holding req after done is re-arbitrated normally; there is no starvation with alternating service.
  - Requesters may drop req at any time before gnt; the request is then withdrawn.
- rdata holds its value until the next read completes for that port. Writes do not change rdata.
- Reset mid-access: strobes deassert asynchronously, the access is abandoned, and no done is issued. SRAM content at the target address is undefined if a write was in progress.
- WAIT_CYCLES outside 1..15 is a compile-time error (assertion in an elaboration block).

Decomposition:
- Package sram_ctrl_pkg:
  - typedef enum logic [1:0] state_t {IDLE, SETUP, ACCESS, FINISH}
  - typedef enum logic req_id_t {REQ_A, REQ_B}
  - localparam WAIT_W = 4
- Sub-module sram_rr_arb: 2-way round-robin arbiter.
  - Inputs: req[1:0], enable (state==IDLE), clk, reset_n.
  - Outputs: gnt[1:0] one-hot, and the winner id.
  - Owns last_served.

Test Plan:
- Read, WAIT_CYCLES=2, memory[0x0010]=0x1234; A reads 0x0010 at T -> a_gnt at T; ce_n/oe_n low T+1..T+3; a_done=1 and a_rdata=0x1234 at T+4; idle strobes at T+4.
- Write, B writes 0xBEEF to 0x0020 at T -> we_n low exactly T+2..T+3; dq_oe high T+1..T+4; a later read of 0x0020 returns 0xBEEF.
- A and B requesting continuously from reset -> gnt order A, B, A, B; gnt spacing 5 cycles (WAIT_CYCLES=2); no done on the wrong port.
- Write immediately followed by a read (and the reverse) -> assertion holds over the whole run: never oe_n=0 && dq_oe=1; we_n=0 implies ce_n=0.
- reset_n pulsed low during a write's ACCESS state -> ce_n/we_n=1 and dq_oe=0 in the same cycle; no b_done; FSM in IDLE after release; next A request is served first.
- WAIT_CYCLES=1 and 15 builds -> done at T+3 and T+17 respectively.
